// File: rtl/ram_byte_loader.sv
// Packs a byte stream into {hi,lo} words written to an external RAM at a wrapping pointer,
// and serves single-word read-back requests through the same address port.
module ram_byte_loader #(
    parameter int ls  = 10,
    parameter int dt1 = 8,
    parameter int dt2 = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [dt1-1:0] byte_in,
    input  logic           byte_valid,
    output logic           byte_ready,
    input  logic           flush,
    input  logic           rd_req,
    input  logic [ls-1:0]  rd_addr,
    output logic           rd_ready,
    output logic [dt2-1:0] rd_data,
    output logic           rd_valid,
    output logic [ls-1:0]  addr,
    output logic [dt2-1:0] datain,
    output logic           wr,
    input  logic [dt2-1:0] ram_dataout,
    output logic [ls-1:0]  word_count,
    output logic           full
);

    typedef enum logic [2:0] {IDLE, LOW, WRITE, READ, CAPTURE} state_t;

    localparam logic [ls-1:0] LAST  = ls'(ls - 1);
    localparam logic [ls-1:0] DEPTH = ls'(ls);
    localparam logic [ls-1:0] ONE   = ls'(1);

    state_t         state_reg, state_next;
    logic [dt1-1:0] lo_reg;
    logic [dt1-1:0] hi_next;
    logic [dt2-1:0] datain_reg;
    logic [ls-1:0]  rd_addr_reg;
    logic [dt2-1:0] rd_data_reg;
    logic           rd_valid_reg;
    logic [ls-1:0]  wptr_reg;
    logic [ls-1:0]  word_count_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    // A pending read request wins over an offered byte while idle.
    always_comb begin
        state_next = state_reg;
        byte_ready = 1'b0;
        rd_ready   = 1'b0;
        wr         = 1'b0;
        addr       = wptr_reg;
        hi_next    = byte_in;
        case (state_reg)
            IDLE: begin
                rd_ready = 1'b1;
                if (rd_req) begin
                    state_next = READ;
                end else begin
                    byte_ready = 1'b1;
                    if (byte_valid) state_next = LOW;
                end
            end
            LOW: begin
                byte_ready = 1'b1;
                if (byte_valid) begin
                    state_next = WRITE;
                end else if (flush) begin
                    hi_next    = '0;
                    state_next = WRITE;
                end
            end
            WRITE: begin
                wr         = 1'b1;
                state_next = IDLE;
            end
            READ: begin
                addr       = rd_addr_reg;
                state_next = CAPTURE;
            end
            CAPTURE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lo_reg         <= '0;
            datain_reg     <= '0;
            rd_addr_reg    <= '0;
            rd_data_reg    <= '0;
            rd_valid_reg   <= 1'b0;
            wptr_reg       <= '0;
            word_count_reg <= '0;
        end else begin
            rd_valid_reg <= 1'b0;
            if (state_reg == IDLE && rd_req)
                rd_addr_reg <= rd_addr;
            if (state_reg == IDLE && !rd_req && byte_valid)
                lo_reg <= byte_in;
            // datain is loaded once on entry to WRITE and then simply held.
            if (state_reg == LOW && state_next == WRITE)
                datain_reg <= dt2'({hi_next, lo_reg});
            if (state_reg == WRITE) begin
                wptr_reg <= (wptr_reg == LAST) ? '0 : wptr_reg + ONE;
                if (word_count_reg != DEPTH)
                    word_count_reg <= word_count_reg + ONE;
            end
            if (state_reg == CAPTURE) begin
                rd_data_reg  <= ram_dataout;
                rd_valid_reg <= 1'b1;
            end
        end
    end

    assign datain     = datain_reg;
    assign rd_data    = rd_data_reg;
    assign rd_valid   = rd_valid_reg;
    assign word_count = word_count_reg;
    assign full       = (word_count_reg == DEPTH);

endmodule

// File: tb/tb_ram_byte_loader.sv
// Randomized bench for ram_byte_loader with a behavioural RAM and a word-level reference model.
module tb_ram_byte_loader;

    localparam int LS = 10;

    logic        clk;
    logic        reset;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        flush;
    logic        rd_req;
    logic [9:0]  rd_addr;
    logic        rd_ready;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic [9:0]  addr;
    logic [15:0] datain;
    logic        wr;
    logic [15:0] ram_dataout;
    logic [9:0]  word_count;
    logic        full;

    int vectors    = 0;
    int miscompares = 0;

    ram_byte_loader #(.ls(LS), .dt1(8), .dt2(16)) dut (
        .clk(clk), .reset(reset),
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .flush(flush),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ready(rd_ready),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .addr(addr), .datain(datain), .wr(wr), .ram_dataout(ram_dataout),
        .word_count(word_count), .full(full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External RAM with registered read, reset held by the inverse of the loader reset.
    logic [15:0] ram_mem [0:1023];
    always @(posedge clk) begin
        if (!reset) begin
            ram_dataout <= '0;
        end else begin
            if (wr) ram_mem[addr] <= datain;
            ram_dataout <= ram_mem[addr];
        end
    end

    // Reference model: word store, next write slot and saturating count.
    logic [15:0] m_mem [LS];
    int          m_wptr;
    int          m_count;

    task automatic model_reset();
        m_wptr  = 0;
        m_count = 0;
    endtask

    task automatic model_write(input logic [15:0] d);
        m_mem[m_wptr] = d;
        m_wptr = (m_wptr + 1) % LS;
        if (m_count < LS) m_count = m_count + 1;
    endtask

    function automatic logic [15:0] expect_word(input logic [7:0] lo, input logic [7:0] hi, input int mode);
        return (mode == 1) ? {8'h00, lo} : {hi, lo};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        model_reset();
    endtask

    // mode 0: two bytes; mode 1: one byte then flush; mode 2: flush together with the hi byte.
    task automatic write_word(input logic [7:0] lo, input logic [7:0] hi, input int mode,
                              output logic o_wr, output logic [9:0] o_addr, output logic [15:0] o_data);
        @(negedge clk);
        byte_in = lo; byte_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        case (mode)
            0:       begin byte_in = hi; byte_valid = 1'b1; end
            1:       begin byte_valid = 1'b0; flush = 1'b1; end
            default: begin byte_in = hi; byte_valid = 1'b1; flush = 1'b1; end
        endcase
        @(posedge clk);
        @(negedge clk);
        byte_valid = 1'b0; flush = 1'b0;
        o_wr = wr; o_addr = addr; o_data = datain;
        @(posedge clk);
        $display("write  addr=%0d data=%h mode=%0d", o_addr, o_data, mode);
    endtask

    task automatic read_word(input logic [9:0] a, output logic [15:0] d, output int lat,
                             output bit got_valid, output bit pulse_ok);
        @(negedge clk);
        rd_req = 1'b1; rd_addr = a;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        rd_req = 1'b0;
        got_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (rd_valid) begin got_valid = 1'b1; break; end
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        d = rd_data;
        @(posedge clk);
        @(negedge clk);
        pulse_ok = !rd_valid;
        $display("read   addr=%0d data=%h latency=%0d", a, d, lat);
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b0;
        #2;
        vectors++; if (wr !== 1'b0) begin miscompares++; $display("FAIL reset_wr: got %b want 0", wr); end
        vectors++; if (addr !== 10'd0) begin miscompares++; $display("FAIL reset_addr: got %0d want 0", addr); end
        vectors++; if (datain !== 16'h0) begin miscompares++; $display("FAIL reset_datain: got %h want 0000", datain); end
        vectors++; if (word_count !== 10'd0) begin miscompares++; $display("FAIL reset_count: got %0d want 0", word_count); end
        vectors++; if (full !== 1'b0) begin miscompares++; $display("FAIL reset_full: got %b want 0", full); end
        vectors++; if (rd_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
        vectors++; if (rd_data !== 16'h0) begin miscompares++; $display("FAIL reset_rd_data: got %h want 0000", rd_data); end
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        #1;
        vectors++; if (byte_ready !== 1'b1) begin miscompares++; $display("FAIL reset_byte_ready: got %b want 1", byte_ready); end
        vectors++; if (rd_ready !== 1'b1) begin miscompares++; $display("FAIL reset_rd_ready: got %b want 1", rd_ready); end
    endtask

    task automatic test_basic_write();
        logic o_wr; logic [9:0] o_addr; logic [15:0] o_data;
        write_word(8'h34, 8'h12, 0, o_wr, o_addr, o_data);
        vectors++; if (o_wr !== 1'b1) begin miscompares++; $display("FAIL basic_wr: got %b want 1", o_wr); end
        vectors++; if (o_addr !== 10'(m_wptr)) begin miscompares++; $display("FAIL basic_addr: got %0d want %0d", o_addr, m_wptr); end
        vectors++; if (o_data !== 16'h1234) begin miscompares++; $display("FAIL basic_data: got %h want 1234", o_data); end
        model_write(16'h1234);
        @(negedge clk);
        vectors++; if (word_count !== 10'(m_count)) begin miscompares++; $display("FAIL basic_count: got %0d want %0d", word_count, m_count); end
        vectors++; if (wr !== 1'b0) begin miscompares++; $display("FAIL basic_wr_drop: got %b want 0", wr); end
        vectors++; if (addr !== 10'(m_wptr)) begin miscompares++; $display("FAIL basic_addr_next: got %0d want %0d", addr, m_wptr); end
        vectors++; if (datain !== 16'h1234) begin miscompares++; $display("FAIL basic_datain_hold: got %h want 1234", datain); end
    endtask

    task automatic test_flush();
        logic o_wr; logic [9:0] o_addr; logic [15:0] o_data;
        logic [7:0] lo, hi;
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        vectors++; if (rd_ready !== 1'b1 || wr !== 1'b0) begin miscompares++; $display("FAIL flush_idle: got rd_ready=%b wr=%b want 1 0", rd_ready, wr); end
        write_word(8'hAB, 8'h55, 1, o_wr, o_addr, o_data);
        vectors++; if (o_wr !== 1'b1 || o_data !== 16'h00AB) begin miscompares++; $display("FAIL flush_data: got wr=%b %h want 1 00ab", o_wr, o_data); end
        vectors++; if (o_addr !== 10'(m_wptr)) begin miscompares++; $display("FAIL flush_addr: got %0d want %0d", o_addr, m_wptr); end
        model_write(16'h00AB);
        lo = 8'($urandom); hi = 8'($urandom);
        write_word(lo, hi, 2, o_wr, o_addr, o_data);
        vectors++; if (o_data !== {hi, lo}) begin miscompares++; $display("FAIL flush_with_byte: got %h want %h", o_data, {hi, lo}); end
        model_write({hi, lo});
    endtask

    task automatic test_full_wrap();
        logic o_wr; logic [9:0] o_addr; logic [15:0] o_data;
        logic [7:0] lo, hi;
        int mode;
        do_reset();
        for (int i = 0; i < LS + 1; i++) begin
            lo = 8'($urandom); hi = 8'($urandom); mode = int'($urandom_range(0, 1));
            write_word(lo, hi, mode, o_wr, o_addr, o_data);
            vectors++; if (o_addr !== 10'(m_wptr) || o_data !== expect_word(lo, hi, mode)) begin
                miscompares++; $display("FAIL fill_write: got addr=%0d data=%h want addr=%0d data=%h", o_addr, o_data, m_wptr, expect_word(lo, hi, mode)); end
            model_write(expect_word(lo, hi, mode));
            if (i == LS - 1 || i == LS) begin
                @(negedge clk);
                vectors++; if (word_count !== 10'd10 || full !== 1'b1) begin
                    miscompares++; $display("FAIL fill_full: got count=%0d full=%b want 10 1", word_count, full); end
            end
        end
    endtask

    task automatic test_random_writes();
        logic o_wr; logic [9:0] o_addr; logic [15:0] o_data;
        logic [7:0] lo, hi;
        int mode;
        do_reset();
        for (int i = 0; i < 15; i++) begin
            lo = 8'($urandom); hi = 8'($urandom); mode = int'($urandom_range(0, 2));
            write_word(lo, hi, mode, o_wr, o_addr, o_data);
            vectors++; if (o_wr !== 1'b1 || o_addr !== 10'(m_wptr) || o_data !== expect_word(lo, hi, mode)) begin
                miscompares++; $display("FAIL rand_write: got wr=%b addr=%0d data=%h want 1 %0d %h", o_wr, o_addr, o_data, m_wptr, expect_word(lo, hi, mode)); end
            model_write(expect_word(lo, hi, mode));
            @(negedge clk);
            vectors++; if (word_count !== 10'(m_count) || full !== (m_count == LS)) begin
                miscompares++; $display("FAIL rand_count: got count=%0d full=%b want %0d %b", word_count, full, m_count, m_count == LS); end
        end
    endtask

    task automatic test_read();
        logic o_wr; logic [9:0] o_addr; logic [15:0] o_data;
        logic [15:0] d;
        logic [9:0] a;
        int lat;
        bit got_valid, pulse_ok;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            d = 16'($urandom);
            write_word(d[7:0], d[15:8], 0, o_wr, o_addr, o_data);
            model_write(d);
        end
        write_word(8'hEF, 8'hBE, 0, o_wr, o_addr, o_data);
        vectors++; if (o_addr !== 10'd3 || o_data !== 16'hBEEF) begin miscompares++; $display("FAIL beef_write: got addr=%0d data=%h want 3 beef", o_addr, o_data); end
        model_write(16'hBEEF);
        read_word(10'd3, d, lat, got_valid, pulse_ok);
        vectors++; if (!got_valid || d !== m_mem[3]) begin miscompares++; $display("FAIL beef_read: got valid=%b data=%h want 1 %h", got_valid, d, m_mem[3]); end
        vectors++; if (lat !== 3) begin miscompares++; $display("FAIL read_latency: got %0d want 3", lat); end
        vectors++; if (!pulse_ok) begin miscompares++; $display("FAIL read_pulse: got rd_valid held want one-cycle pulse"); end
        for (int i = 0; i < 6; i++) begin
            d = 16'($urandom);
            write_word(d[7:0], d[15:8], 0, o_wr, o_addr, o_data);
            model_write(d);
        end
        for (int i = 0; i < 6; i++) begin
            a = 10'($urandom_range(0, LS - 1));
            read_word(a, d, lat, got_valid, pulse_ok);
            vectors++; if (!got_valid || d !== m_mem[a] || lat !== 3) begin
                miscompares++; $display("FAIL rand_read: addr=%0d got valid=%b data=%h lat=%0d want 1 %h 3", a, got_valid, d, lat, m_mem[a]); end
        end
    endtask

    task automatic test_priority();
        logic [7:0] lo, hi;
        logic [9:0] a;
        lo = 8'($urandom); hi = 8'($urandom);
        a = 10'($urandom_range(0, LS - 1));
        @(negedge clk);
        rd_req = 1'b1; rd_addr = a; byte_valid = 1'b1; byte_in = lo;
        #1;
        vectors++; if (byte_ready !== 1'b0 || rd_ready !== 1'b1) begin miscompares++; $display("FAIL prio_accept: got byte_ready=%b rd_ready=%b want 0 1", byte_ready, rd_ready); end
        @(posedge clk);
        @(negedge clk);
        rd_req = 1'b0;
        vectors++; if (byte_ready !== 1'b0 || rd_ready !== 1'b0) begin miscompares++; $display("FAIL prio_read_stall: got byte_ready=%b rd_ready=%b want 0 0", byte_ready, rd_ready); end
        @(posedge clk);
        @(negedge clk);
        vectors++; if (byte_ready !== 1'b0) begin miscompares++; $display("FAIL prio_capture_stall: got %b want 0", byte_ready); end
        @(posedge clk);
        @(negedge clk);
        vectors++; if (rd_valid !== 1'b1 || rd_data !== m_mem[a] || byte_ready !== 1'b1) begin
            miscompares++; $display("FAIL prio_read: got valid=%b data=%h byte_ready=%b want 1 %h 1", rd_valid, rd_data, byte_ready, m_mem[a]); end
        $display("read   addr=%0d data=%h (byte held)", a, rd_data);
        @(posedge clk);
        @(negedge clk);
        byte_in = hi;
        @(posedge clk);
        @(negedge clk);
        byte_valid = 1'b0;
        vectors++; if (wr !== 1'b1 || addr !== 10'(m_wptr) || datain !== {hi, lo}) begin
            miscompares++; $display("FAIL prio_write: got wr=%b addr=%0d data=%h want 1 %0d %h", wr, addr, datain, m_wptr, {hi, lo}); end
        $display("write  addr=%0d data=%h (after read)", addr, datain);
        model_write({hi, lo});
        @(posedge clk);
    endtask

    task automatic test_reset_mid_write();
        logic o_wr; logic [9:0] o_addr; logic [15:0] o_data;
        logic [7:0] lo, hi;
        @(negedge clk);
        byte_in = 8'($urandom); byte_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        byte_in = 8'($urandom);
        @(posedge clk);
        @(negedge clk);
        byte_valid = 1'b0;
        vectors++; if (wr !== 1'b1) begin miscompares++; $display("FAIL midwr_in_write: got %b want 1", wr); end
        #2 reset = 1'b0;
        #1;
        vectors++; if (wr !== 1'b0 || addr !== 10'd0 || datain !== 16'h0) begin
            miscompares++; $display("FAIL midwr_outputs: got wr=%b addr=%0d data=%h want 0 0 0000", wr, addr, datain); end
        vectors++; if (word_count !== 10'd0 || full !== 1'b0) begin
            miscompares++; $display("FAIL midwr_count: got count=%0d full=%b want 0 0", word_count, full); end
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        lo = 8'($urandom); hi = 8'($urandom);
        write_word(lo, hi, 0, o_wr, o_addr, o_data);
        vectors++; if (o_addr !== 10'd0 || o_data !== {hi, lo}) begin
            miscompares++; $display("FAIL midwr_next: got addr=%0d data=%h want 0 %h", o_addr, o_data, {hi, lo}); end
        model_write({hi, lo});
        @(negedge clk);
        vectors++; if (word_count !== 10'(m_count)) begin miscompares++; $display("FAIL midwr_recount: got %0d want %0d", word_count, m_count); end
    endtask

    initial begin
        reset = 1'b1; byte_in = '0; byte_valid = 1'b0; flush = 1'b0;
        rd_req = 1'b0; rd_addr = '0;
        model_reset();
        #3 reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        test_reset();
        test_basic_write();
        test_flush();
        test_full_wrap();
        test_random_writes();
        test_read();
        test_priority();
        test_reset_mid_write();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ram_byte_loader.md
RAM_BYTE_LOADER -- requirements
Module: ram_byte_loader

Interface
REQ-001 SHALL have parameter ls, default 10, meaning RAM address width and depth (locations 0..ls-1).
REQ-002 SHALL have parameter dt1, default 8, meaning byte width.
REQ-003 SHALL have parameter dt2, default 16, meaning word width (2*dt1).
REQ-004 SHALL have port clk  input  1  meaning the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  meaning asynchronous, active-low reset.
REQ-006 SHALL have port byte_in  input  dt1  meaning the upstream byte.
REQ-007 SHALL have port byte_valid  input  1  meaning byte_in is valid.
REQ-008 SHALL have port byte_ready  output  1  meaning the loader accepts a byte this cycle.
REQ-009 SHALL have port flush  input  1  meaning write any pending low byte now.
REQ-010 SHALL have port rd_req  input  1  meaning read-back request.
REQ-011 SHALL have port rd_addr  input  ls  meaning read-back location.
REQ-012 SHALL have port rd_ready  output  1  meaning rd_req is accepted this cycle.
REQ-013 SHALL have port rd_data  output  dt2  meaning captured read word.
REQ-014 SHALL have port rd_valid  output  1  meaning a one-cycle pulse marking rd_data as new.
REQ-015 SHALL have port addr  output  ls  meaning the RAM address.
REQ-016 SHALL have port datain  output  dt2  meaning the RAM write word.
REQ-017 SHALL have port wr  output  1  meaning RAM write strobe.
REQ-018 SHALL have port ram_dataout  input  dt2  meaning RAM registered read data.
REQ-019 SHALL have port word_count  output  ls  meaning words written, saturating at ls.
REQ-020 SHALL have port full  output  1  meaning word_count == ls.

Function
REQ-021 SHALL implement FSM states IDLE, LOW, WRITE, READ, CAPTURE, with a write pointer wptr.
REQ-022 SHALL handshake as follows: a byte transfers only on a cycle with byte_valid=1 and byte_ready=1; byte_ready=1 in IDLE and LOW, 0 otherwise.
REQ-023 SHALL transition IDLE->LOW on a byte transfer, registering lo=byte_in.
REQ-024 SHALL transition LOW->WRITE on a byte transfer, registering hi=byte_in.
REQ-025 SHALL handle flush=1 in LOW with no byte transfer by setting hi=0 and going LOW->WRITE; if flush=1 and a byte transfers in the same cycle, the byte SHALL be used as hi.
REQ-026 SHALL ignore flush in IDLE, WRITE, READ and CAPTURE.
REQ-027 SHALL, in WRITE, hold wr=1, addr=wptr and datain={hi,lo} for exactly one cycle, then go to IDLE.
REQ-028 SHALL, on leaving WRITE, advance wptr: ls-1 wraps to 0, otherwise +1.
REQ-029 SHALL increment word_count on each WRITE, saturating at ls.
REQ-030 SHALL keep writing and overwriting after full is set (wrap-around).
REQ-031 SHALL set rd_ready=1 only in IDLE; rd_req=1 in IDLE goes IDLE->READ and registers rd_addr.
REQ-032 SHALL give rd_req priority over byte_valid in IDLE; byte_ready SHALL be 0 in that cycle.
REQ-033 SHALL, in READ, drive wr=0 and addr=the registered rd_addr for one cycle, then go to CAPTURE.
REQ-034 SHALL, in CAPTURE, register rd_data=ram_dataout at the end of the cycle, pulse rd_valid=1 for the following cycle, and go to IDLE.
REQ-035 SHALL have a read latency, from the rd_req accept edge to rd_valid high, of 3 clock edges.
REQ-036 SHALL, outside WRITE and READ, drive wr=0 and addr=wptr, and hold datain at its last value.
REQ-037 SHALL leave rd_req unaccepted in LOW or WRITE; the requester holds rd_req until rd_ready.

Reset
REQ-038 SHALL, on reset=0 at any time (including mid-WRITE or mid-READ), immediately force: state IDLE, wptr=0, word_count=0, full=0, wr=0, addr=0, datain=0, rd_data=0, rd_valid=0, pending lo/hi discarded.
REQ-039 SHALL drive byte_ready=1 and rd_ready=1 while in IDLE after reset.
REQ-040 SHALL make the system top drive the RAM's active-high synchronous reset with the inverse of reset.

Verification
REQ-041 SHALL cover: bytes 0x34,0x12 -> one cycle with wr=1, addr=0, datain=0x1234; then word_count=1.
REQ-042 SHALL cover: 10 word pairs -> full=1, word_count=10; an 11th word -> written at addr=0, count stays 10.
REQ-043 SHALL cover: byte 0xAB then flush -> wr=1, datain=0x00AB.
REQ-044 SHALL cover: write 0xBEEF at addr 3, then rd_req with rd_addr=3 -> rd_valid pulse with rd_data=0xBEEF, 3 edges after accept.
REQ-045 SHALL cover: rd_req and byte_valid together in IDLE -> read accepted, byte_ready=0, byte transfers after CAPTURE.
REQ-046 SHALL cover: reset asserted during WRITE -> wr=0 immediately, word_count=0, next word written at addr=0.
